// File: rtl/pcs_pkg.sv
// Shared types for the PCS TX stream checker: default word width and the checker state encoding.
package pcs_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_CHECK  = 2'd1,
        ST_HALT   = 2'd2
    } chk_state_t;

endpackage

// File: rtl/pcs_sync_fifo.sv
// Single-clock expected-word queue with synchronous reset/flush and no write-to-read bypass.
module pcs_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overflow_evt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign do_pop       = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on a full queue still lands.
    assign do_push      = push && (!full || do_pop);
    assign overflow_evt = push && full && !do_pop;
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcs_tx_stream_checker.sv
// In-line checker: queues golden TX words and compares them against PCS output strobes
// after a warm-up window, with saturating counters and first-mismatch capture.
module pcs_tx_stream_checker
    import pcs_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SKIP_CNT    = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_WIDTH   = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_exp_data,
    input  logic                  i_exp_valid,
    input  logic [DATA_WIDTH-1:0] i_dut_data,
    input  logic                  i_dut_strobe,
    output logic [CNT_WIDTH-1:0]  o_match_cnt,
    output logic [CNT_WIDTH-1:0]  o_mismatch_cnt,
    output logic [CNT_WIDTH-1:0]  o_underflow_cnt,
    output logic                  o_overflow,
    output logic [DATA_WIDTH-1:0] o_first_err_exp,
    output logic [DATA_WIDTH-1:0] o_first_err_dut,
    output logic                  o_halted,
    output logic                  o_pass
);

    localparam int SW = (SKIP_CNT > 0) ? $clog2(SKIP_CNT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    chk_state_t            state;
    chk_state_t            state_nxt;
    logic [SW-1:0]         skip_cnt;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_ovf;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  cmp_match;
    logic                  cmp_mismatch;
    logic                  underflow_evt;

    pcs_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (i_clk),
        .reset        (i_reset),
        .flush        (i_clear),
        .push         (i_exp_valid),
        .push_data    (i_exp_data),
        .pop          (fifo_pop),
        .head         (fifo_head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow_evt (fifo_ovf)
    );

    always_comb begin
        state_nxt     = state;
        fifo_pop      = 1'b0;
        cmp_match     = 1'b0;
        cmp_mismatch  = 1'b0;
        underflow_evt = 1'b0;
        case (state)
            ST_WARMUP: begin
                if (SKIP_CNT == 0) begin
                    state_nxt = ST_CHECK;
                end else if (i_dut_strobe && (skip_cnt == SW'(SKIP_CNT - 1))) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (i_dut_strobe) begin
                    if (fifo_empty) begin
                        underflow_evt = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        if (fifo_head == i_dut_data) begin
                            cmp_match = 1'b1;
                        end else begin
                            cmp_mismatch = 1'b1;
                            if (STOP_ON_ERR) begin
                                state_nxt = ST_HALT;
                            end
                        end
                    end
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_WARMUP;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            state           <= ST_WARMUP;
            skip_cnt        <= '0;
            o_match_cnt     <= '0;
            o_mismatch_cnt  <= '0;
            o_underflow_cnt <= '0;
            o_overflow      <= 1'b0;
            o_first_err_exp <= '0;
            o_first_err_dut <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_WARMUP) && i_dut_strobe && (SKIP_CNT != 0)) begin
                skip_cnt <= skip_cnt + SW'(1);
            end
            if (cmp_match && (o_match_cnt != CNT_MAX)) begin
                o_match_cnt <= o_match_cnt + CNT_ONE;
            end
            if (cmp_mismatch && (o_mismatch_cnt != CNT_MAX)) begin
                o_mismatch_cnt <= o_mismatch_cnt + CNT_ONE;
            end
            if (underflow_evt && (o_underflow_cnt != CNT_MAX)) begin
                o_underflow_cnt <= o_underflow_cnt + CNT_ONE;
            end
            // Saturating counter never returns to zero, so zero means no mismatch captured yet.
            if (cmp_mismatch && (o_mismatch_cnt == '0)) begin
                o_first_err_exp <= fifo_head;
                o_first_err_dut <= i_dut_data;
            end
            if (fifo_ovf) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign o_halted = (state == ST_HALT);
    assign o_pass   = (state == ST_CHECK) && (o_match_cnt != '0) && (o_mismatch_cnt == '0)
                      && (o_underflow_cnt == '0) && !o_overflow;

endmodule

// File: tb/tb_pcs_tx_stream_checker.sv
// Scoreboard bench for pcs_tx_stream_checker: three parameter variants share one stimulus bus.
module tb_pcs_tx_stream_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic [31:0] dut_data;
    logic        dut_strobe;

    logic [15:0] a_match, a_mism, a_under;
    logic        a_ovf, a_halt, a_pass;
    logic [31:0] a_fe, a_fd;
    logic [15:0] b_match, b_mism, b_under;
    logic        b_ovf, b_halt, b_pass;
    logic [31:0] b_fe, b_fd;
    logic [3:0]  c_match, c_mism, c_under;
    logic        c_ovf, c_halt, c_pass;
    logic [31:0] c_fe, c_fd;

    int cycle = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    pcs_tx_stream_checker #(.SKIP_CNT(3), .FIFO_DEPTH(8), .CNT_WIDTH(16), .STOP_ON_ERR(1'b0)) u_a (
        .i_clk(clk), .i_reset(reset), .i_clear(clear),
        .i_exp_data(exp_data), .i_exp_valid(exp_valid),
        .i_dut_data(dut_data), .i_dut_strobe(dut_strobe),
        .o_match_cnt(a_match), .o_mismatch_cnt(a_mism), .o_underflow_cnt(a_under),
        .o_overflow(a_ovf), .o_first_err_exp(a_fe), .o_first_err_dut(a_fd),
        .o_halted(a_halt), .o_pass(a_pass));

    pcs_tx_stream_checker #(.SKIP_CNT(3), .FIFO_DEPTH(8), .CNT_WIDTH(16), .STOP_ON_ERR(1'b1)) u_b (
        .i_clk(clk), .i_reset(reset), .i_clear(clear),
        .i_exp_data(exp_data), .i_exp_valid(exp_valid),
        .i_dut_data(dut_data), .i_dut_strobe(dut_strobe),
        .o_match_cnt(b_match), .o_mismatch_cnt(b_mism), .o_underflow_cnt(b_under),
        .o_overflow(b_ovf), .o_first_err_exp(b_fe), .o_first_err_dut(b_fd),
        .o_halted(b_halt), .o_pass(b_pass));

    pcs_tx_stream_checker #(.SKIP_CNT(3), .FIFO_DEPTH(8), .CNT_WIDTH(4), .STOP_ON_ERR(1'b0)) u_c (
        .i_clk(clk), .i_reset(reset), .i_clear(clear),
        .i_exp_data(exp_data), .i_exp_valid(exp_valid),
        .i_dut_data(dut_data), .i_dut_strobe(dut_strobe),
        .o_match_cnt(c_match), .o_mismatch_cnt(c_mism), .o_underflow_cnt(c_under),
        .o_overflow(c_ovf), .o_first_err_exp(c_fe), .o_first_err_dut(c_fd),
        .o_halted(c_halt), .o_pass(c_pass));

    typedef struct {
        string       name;
        int          inst;
        int          at;
        int          match;
        int          mism;
        int          under;
        int          ovf;
        int          pass;
        int          halt;
        bit          chk_ferr;
        logic [31:0] fe;
        logic [31:0] fd;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] w(input int k);
        return 32'hA5A5_0000 + 32'(k) * 32'h0001_0011;
    endfunction

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s: actual=%0h required=%0h", nm, field, act, req);
        end
    endtask

    // Monitor: pops expected snapshots once their cycle is reached and compares the chosen instance.
    exp_t        e;
    logic [31:0] am, amm, au, aov, ap, ah, afe, afd;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cycle) begin
            e = sb.pop_front();
            case (e.inst)
                0: begin
                    am = 32'(a_match); amm = 32'(a_mism); au = 32'(a_under);
                    aov = 32'(a_ovf); ap = 32'(a_pass); ah = 32'(a_halt); afe = a_fe; afd = a_fd;
                end
                1: begin
                    am = 32'(b_match); amm = 32'(b_mism); au = 32'(b_under);
                    aov = 32'(b_ovf); ap = 32'(b_pass); ah = 32'(b_halt); afe = b_fe; afd = b_fd;
                end
                default: begin
                    am = 32'(c_match); amm = 32'(c_mism); au = 32'(c_under);
                    aov = 32'(c_ovf); ap = 32'(c_pass); ah = 32'(c_halt); afe = c_fe; afd = c_fd;
                end
            endcase
            chk(e.name, "match", am, 32'(e.match));
            chk(e.name, "mismatch", amm, 32'(e.mism));
            chk(e.name, "underflow", au, 32'(e.under));
            chk(e.name, "overflow", aov, 32'(e.ovf));
            chk(e.name, "pass", ap, 32'(e.pass));
            chk(e.name, "halted", ah, 32'(e.halt));
            if (e.chk_ferr) begin
                chk(e.name, "first_err_exp", afe, e.fe);
                chk(e.name, "first_err_dut", afd, e.fd);
            end
        end
    end

    task automatic expect_now(input string nm, input int inst, input int m, input int mm, input int u,
                              input int o, input int p, input int h, input bit cf,
                              input logic [31:0] fe, input logic [31:0] fd);
        exp_t x;
        x.name = nm; x.inst = inst; x.at = cycle;
        x.match = m; x.mism = mm; x.under = u; x.ovf = o; x.pass = p; x.halt = h;
        x.chk_ferr = cf; x.fe = fe; x.fd = fd;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exp_valid = 1'b0; exp_data = '0; dut_strobe = 1'b0; dut_data = '0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Golden word k pushed at step k; PCS returns it 3 strobes later; c1/c2 pick corrupted words.
    task automatic run_stream(input int n_words, input int n_strobes, input int c1, input int c2);
        for (int c = 0; c < n_strobes; c++) begin
            exp_valid  = (c < n_words);
            exp_data   = w(c);
            dut_strobe = 1'b1;
            if (c >= 3)
                dut_data = w(c - 3) ^ (((c - 3) == c1 || (c - 3) == c2) ? 32'h1 : 32'h0);
            else
                dut_data = 32'hDEAD_0000 + 32'(c);
            tick();
        end
        idle();
    endtask

    task automatic strobes(input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            dut_strobe = 1'b1; dut_data = d;
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        clear = 1'b0;
        reset = 1'b1;
        tick(); tick();
        // Reset must also win over a simultaneous clear.
        clear = 1'b1;
        tick();
        reset = 1'b0;
        clear = 1'b0;
        expect_now("reset_a", 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0, 32'h0);
        expect_now("reset_b", 1, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0, 32'h0);
        expect_now("reset_c", 2, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0, 32'h0);
        tick();

        do_clear();
        run_stream(10, 13, -1, -1);
        expect_now("clean_a", 0, 10, 0, 0, 0, 1, 0, 1'b1, 32'h0, 32'h0);
        expect_now("clean_b", 1, 10, 0, 0, 0, 1, 0, 1'b0, 32'h0, 32'h0);
        expect_now("clean_c", 2, 10, 0, 0, 0, 1, 0, 1'b0, 32'h0, 32'h0);
        tick();

        do_clear();
        run_stream(10, 13, 4, -1);
        expect_now("corrupt5_a", 0, 9, 1, 0, 0, 0, 0, 1'b1, w(4), w(4) ^ 32'h1);
        tick();

        do_clear();
        run_stream(10, 13, 3, 6);
        expect_now("stop_b", 1, 3, 1, 0, 0, 0, 1, 1'b1, w(3), w(3) ^ 32'h1);
        expect_now("nostop_a", 0, 8, 2, 0, 0, 0, 0, 1'b1, w(3), w(3) ^ 32'h1);
        strobes(4, 32'h1234_5678);
        expect_now("frozen_b", 1, 3, 1, 0, 0, 0, 1, 1'b1, w(3), w(3) ^ 32'h1);
        tick();

        do_clear();
        run_stream(20, 23, -1, -1);
        expect_now("sat_c", 2, 15, 0, 0, 0, 1, 0, 1'b0, 32'h0, 32'h0);
        expect_now("nosat_a", 0, 20, 0, 0, 0, 1, 0, 1'b0, 32'h0, 32'h0);
        tick();

        do_clear();
        run_stream(10, 6, -1, -1);
        expect_now("mid_a", 0, 3, 0, 0, 0, 1, 0, 1'b0, 32'h0, 32'h0);
        do_clear();
        expect_now("midclr_a", 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0, 32'h0);
        expect_now("midclr_c", 2, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0, 32'h0);
        strobes(3, 32'h0);
        expect_now("rewarm_a", 0, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0, 32'h0);
        strobes(1, 32'h0);
        expect_now("rewarm_under_a", 0, 0, 0, 1, 0, 0, 0, 1'b0, 32'h0, 32'h0);
        tick();

        do_clear();
        for (int k = 0; k < 9; k++) begin
            exp_valid = 1'b1; exp_data = w(k);
            tick();
        end
        idle();
        expect_now("overflow_a", 0, 0, 0, 0, 1, 0, 0, 1'b0, 32'h0, 32'h0);
        tick();

        do_clear();
        strobes(3, 32'h0);
        for (int k = 0; k < 8; k++) begin
            exp_valid = 1'b1; exp_data = w(k);
            tick();
        end
        exp_valid = 1'b1; exp_data = w(8); dut_strobe = 1'b1; dut_data = w(0);
        tick();
        idle();
        expect_now("fullpushpop_a", 0, 1, 0, 0, 0, 1, 0, 1'b0, 32'h0, 32'h0);
        strobes(1, w(1));
        expect_now("fullnext_a", 0, 2, 0, 0, 0, 1, 0, 1'b0, 32'h0, 32'h0);
        tick();

        do_clear();
        strobes(3, 32'h0);
        exp_valid = 1'b1; exp_data = w(50); dut_strobe = 1'b1; dut_data = 32'hBAD0_0000;
        tick();
        idle();
        expect_now("underflow_a", 0, 0, 0, 1, 0, 0, 0, 1'b0, 32'h0, 32'h0);
        strobes(1, w(50));
        expect_now("afterunder_a", 0, 1, 0, 1, 0, 0, 0, 1'b1, 32'h0, 32'h0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
